// File: rtl/accum_pkg.sv
// Shared types and defaults for the running-sum accumulator.
// The default width sets the interface default and the bench's value type.
package accum_pkg;

    localparam int ACCUM_DEF_WIDTH = 32;

    typedef logic [ACCUM_DEF_WIDTH-1:0] accum_t;

endpackage : accum_pkg

// File: rtl/accum_if.sv
// Data bundle between the accumulator and its user.
// The user drives amt every cycle and observes the registered sum.
interface accum_if
    import accum_pkg::*;
#(
    parameter int WIDTH = ACCUM_DEF_WIDTH
);

    logic [WIDTH-1:0] amt;
    logic [WIDTH-1:0] sum;

    modport master (
        output amt,
        input  sum
    );

    modport slave (
        input  amt,
        output sum
    );

endinterface : accum_if

// File: rtl/accum_add.sv
// Combinational WIDTH-bit unsigned adder with carry-out.
// When sat is set, an overflowing result is clamped to all-ones instead of wrapping.
module accum_add
    import accum_pkg::*;
#(
    parameter int WIDTH = ACCUM_DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sat,
    output logic [WIDTH-1:0] y,
    output logic             carry
);

    logic [WIDTH:0] full_s;

    // Widen by one bit so the carry-out is captured, then pick wrap or clamp.
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b};
        carry  = full_s[WIDTH];
        if (sat && full_s[WIDTH]) begin
            y = {WIDTH{1'b1}};
        end else begin
            y = full_s[WIDTH-1:0];
        end
    end

endmodule : accum_add

// File: rtl/accum.sv
// Running-sum accumulator: every rising clk edge adds amt into the sum register.
// reset is asynchronous active-low and forces the sum to zero immediately.
module accum
    import accum_pkg::*;
#(
    parameter int WIDTH    = ACCUM_DEF_WIDTH,
    parameter int SATURATE = 0
) (
    input  logic    clk,
    input  logic    reset,
    accum_if.slave  bus
);

    localparam logic SAT_EN = (SATURATE != 0) ? 1'b1 : 1'b0;

    logic [WIDTH-1:0] sum_q;
    logic [WIDTH-1:0] sum_d;
    logic             carry_s;

    accum_add #(
        .WIDTH (WIDTH)
    ) u_add (
        .a     (sum_q),
        .b     (bus.amt),
        .sat   (SAT_EN),
        .y     (sum_d),
        .carry (carry_s)
    );

    // Sum register; the carry only matters inside the adder's clamp decision.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sum_q <= {WIDTH{1'b0}};
        end else begin
            sum_q <= sum_d;
        end
    end

    logic unused_s;
    assign unused_s = carry_s;

    assign bus.sum = sum_q;

endmodule : accum

// File: tb/tb_accum.sv
// Directed bench for accum: a wrapping and a saturating instance share clk, reset and amt.
// Expected sums are hand-computed constants.
module tb_accum;
    import accum_pkg::*;

    logic   clk;
    logic   reset;
    accum_t amt;
    int     n_cmp;
    int     n_err;

    accum_if #(.WIDTH(ACCUM_DEF_WIDTH)) bus_wrap ();
    accum_if #(.WIDTH(ACCUM_DEF_WIDTH)) bus_sat ();

    assign bus_wrap.amt = amt;
    assign bus_sat.amt  = amt;

    accum #(
        .WIDTH    (ACCUM_DEF_WIDTH),
        .SATURATE (0)
    ) dut_wrap (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_wrap.slave)
    );

    accum #(
        .WIDTH    (ACCUM_DEF_WIDTH),
        .SATURATE (1)
    ) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_sat.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input accum_t got, input accum_t exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic check_both(input string tag, input accum_t exp_wrap, input accum_t exp_sat);
        check_val({tag, "/wrap"}, bus_wrap.sum, exp_wrap);
        check_val({tag, "/sat"},  bus_sat.sum,  exp_sat);
    endtask

    // Drive amt away from the edge, then sample 1 time unit after the next rising edge.
    task automatic tick(input accum_t a);
        amt = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        amt   = 32'd5;

        // Held in reset with a nonzero amount.
        tick(32'd5); check_both("rst_hold1", 32'd0, 32'd0);
        tick(32'd5); check_both("rst_hold2", 32'd0, 32'd0);

        reset = 1'b1;
        tick(32'd1); check_both("count1", 32'd1, 32'd1);
        tick(32'd1); check_both("count2", 32'd2, 32'd2);
        tick(32'd1); check_both("count3", 32'd3, 32'd3);

        // Asynchronous reset between edges.
        #2;
        reset = 1'b0;
        #1;
        check_both("async_rst", 32'd0, 32'd0);
        tick(32'd1); check_both("rst_edge", 32'd0, 32'd0);
        reset = 1'b1;
        tick(32'd1); check_both("recount1", 32'd1, 32'd1);
        tick(32'd1); check_both("recount2", 32'd2, 32'd2);
        tick(32'd1); check_both("recount3", 32'd3, 32'd3);

        // Hold with amt == 0, then step by 0x10.
        tick(32'd4); check_both("to7", 32'd7, 32'd7);
        for (int i = 0; i < 4; i++) begin
            tick(32'd0); check_both("hold7", 32'd7, 32'd7);
        end
        tick(32'h10); check_both("add17", 32'h17, 32'h17);
        tick(32'h10); check_both("add27", 32'h27, 32'h27);

        // Overflow: wrap versus clamp.
        reset = 1'b0;
        #1;
        check_both("rst_ovf", 32'd0, 32'd0);
        reset = 1'b1;
        tick(32'hFFFF_FFFE); check_both("preload", 32'hFFFF_FFFE, 32'hFFFF_FFFE);
        tick(32'd3);         check_both("ovf3",    32'h0000_0001, 32'hFFFF_FFFF);
        tick(32'd1);         check_both("post1",   32'h0000_0002, 32'hFFFF_FFFF);
        tick(32'd0);         check_both("post0",   32'h0000_0002, 32'hFFFF_FFFF);

        // All-ones plus one.
        reset = 1'b0;
        #1;
        reset = 1'b1;
        tick(32'hFFFF_FFFF); check_both("allones", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        tick(32'd1);         check_both("ones_p1", 32'h0000_0000, 32'hFFFF_FFFF);
        tick(32'd2);         check_both("ones_p2", 32'h0000_0002, 32'hFFFF_FFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_accum
